// File: rtl/fcml_cmd_pkg.sv
// Shared definitions for the FCML command sequencer: frame address map,
// control-word bit positions, sequencer states and the frame parity check.
package fcml_cmd_pkg;

  localparam logic [3:0] ADDR_DUTY_A = 4'd0;
  localparam logic [3:0] ADDR_DUTY_B = 4'd1;
  localparam logic [3:0] ADDR_DUTY_C = 4'd2;
  localparam logic [3:0] ADDR_CTRL   = 4'd3;

  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_FCLR_BIT = 1;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_ARMED = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  // Even parity over the whole 33-bit frame, parity bit included.
  function automatic logic frame_parity_ok(input logic [32:0] frame);
    return (^frame) == 1'b0;
  endfunction

endpackage

// File: rtl/cmd_watchdog.sv
// Host-activity watchdog: counts clk cycles since the last kick and flags
// a single-cycle expire when the count reaches WDOG_CYCLES-1.
module cmd_watchdog #(
  parameter int WDOG_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic kick,
  output logic expire
);

  localparam int CNT_W = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WDOG_CYCLES - 1);

  logic [CNT_W-1:0] count;
  logic             at_last;

  assign at_last = (count == LAST);
  // A kick in the expiry cycle wins, so a good frame always prevents a fault.
  assign expire  = at_last && !kick;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (kick || at_last) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/fcml_cmd_sequencer.sv
// Validates SPI command frames, fills shadow duty/control registers and
// commits them atomically to the modulators on carrier sync, with a watchdog fault.
module fcml_cmd_sequencer
  import fcml_cmd_pkg::*;
#(
  parameter int DUTY_W      = 16,
  parameter int WDOG_CYCLES = 1_000_000,
  parameter int ERRCNT_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [32:0]         frame_data,
  input  logic                frame_valid,
  input  logic                carrier_sync,
  output logic [DUTY_W-1:0]   duty_a,
  output logic [DUTY_W-1:0]   duty_b,
  output logic [DUTY_W-1:0]   duty_c,
  output logic                pwm_enable,
  output logic                fault,
  output logic                commit_pending,
  output logic [ERRCNT_W-1:0] frame_err_cnt
);

  state_t state, next_state;

  logic [3:0]        addr;
  logic              good_frame;
  logic              ctrl_wr;
  logic              expire;
  logic              do_commit;
  logic              do_fault;
  logic [DUTY_W-1:0] sh_a, sh_b, sh_c;
  logic              sh_en;

  assign addr       = frame_data[31:28];
  assign good_frame = frame_valid && frame_parity_ok(frame_data) && (addr <= ADDR_CTRL);
  assign ctrl_wr    = good_frame && (addr == ADDR_CTRL);

  assign commit_pending = (state == ST_ARMED);
  assign fault          = (state == ST_FAULT);

  cmd_watchdog #(
    .WDOG_CYCLES(WDOG_CYCLES)
  ) u_wdog (
    .clk   (clk),
    .rst   (rst),
    .kick  (good_frame),
    .expire(expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_RUN;
    end else begin
      state <= next_state;
    end
  end

  // Expiry outranks a pending commit; a control write in the commit cycle re-arms.
  always_comb begin
    next_state = state;
    do_commit  = 1'b0;
    do_fault   = 1'b0;
    case (state)
      ST_RUN: begin
        if (expire) begin
          next_state = ST_FAULT;
          do_fault   = 1'b1;
        end else if (ctrl_wr) begin
          next_state = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (expire) begin
          next_state = ST_FAULT;
          do_fault   = 1'b1;
        end else if (carrier_sync) begin
          do_commit  = 1'b1;
          next_state = ctrl_wr ? ST_ARMED : ST_RUN;
        end
      end
      ST_FAULT: begin
        if (ctrl_wr && frame_data[CTRL_FCLR_BIT]) begin
          next_state = ST_ARMED;
        end
      end
      default: next_state = ST_RUN;
    endcase
  end

  // Commit reads the shadows before this cycle's frame write lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_a       <= '0;
      sh_b       <= '0;
      sh_c       <= '0;
      sh_en      <= 1'b0;
      duty_a     <= '0;
      duty_b     <= '0;
      duty_c     <= '0;
      pwm_enable <= 1'b0;
    end else begin
      if (good_frame) begin
        case (addr)
          ADDR_DUTY_A: sh_a  <= frame_data[DUTY_W-1:0];
          ADDR_DUTY_B: sh_b  <= frame_data[DUTY_W-1:0];
          ADDR_DUTY_C: sh_c  <= frame_data[DUTY_W-1:0];
          ADDR_CTRL:   sh_en <= frame_data[CTRL_EN_BIT];
          default: ;
        endcase
      end
      if (do_fault) begin
        duty_a     <= '0;
        duty_b     <= '0;
        duty_c     <= '0;
        pwm_enable <= 1'b0;
      end else if (do_commit) begin
        duty_a     <= sh_a;
        duty_b     <= sh_b;
        duty_c     <= sh_c;
        pwm_enable <= sh_en;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_err_cnt <= '0;
    end else if (frame_valid && !good_frame && (frame_err_cnt != '1)) begin
      frame_err_cnt <= frame_err_cnt + ERRCNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fcml_cmd_sequencer.sv
// Scoreboard bench for fcml_cmd_sequencer: a behavioural model predicts the
// visible outputs each cycle, and key spec scenarios are also checked against constants.
module tb_fcml_cmd_sequencer;

  localparam int DUTY_W   = 16;
  localparam int WDOG     = 100;
  localparam int ERRCNT_W = 8;

  logic                clk;
  logic                rst;
  logic [32:0]         frame_data;
  logic                frame_valid;
  logic                carrier_sync;
  logic [DUTY_W-1:0]   duty_a, duty_b, duty_c;
  logic                pwm_enable;
  logic                fault;
  logic                commit_pending;
  logic [ERRCNT_W-1:0] frame_err_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] c;
    logic        en;
    logic        flt;
    logic        pend;
    logic [7:0]  err;
  } exp_t;

  exp_t exp_q[$];

  // Behavioural model state
  logic [15:0] m_sh_a, m_sh_b, m_sh_c, m_act_a, m_act_b, m_act_c;
  logic        m_sh_en, m_en, m_fault, m_pend;
  int          m_err, m_wd;

  fcml_cmd_sequencer #(
    .DUTY_W     (DUTY_W),
    .WDOG_CYCLES(WDOG),
    .ERRCNT_W   (ERRCNT_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .frame_data    (frame_data),
    .frame_valid   (frame_valid),
    .carrier_sync  (carrier_sync),
    .duty_a        (duty_a),
    .duty_b        (duty_b),
    .duty_c        (duty_c),
    .pwm_enable    (pwm_enable),
    .fault         (fault),
    .commit_pending(commit_pending),
    .frame_err_cnt (frame_err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
    end
  endtask

  function automatic logic [32:0] makeFrame(input logic [3:0] addr, input logic [27:0] payload, input logic bad_parity);
    logic [32:0] f;
    f = {1'b0, addr, payload};
    f[32] = (^f[31:0]) ^ bad_parity;
    return f;
  endfunction

  task automatic modelReset();
    m_sh_a = '0; m_sh_b = '0; m_sh_c = '0; m_sh_en = 1'b0;
    m_act_a = '0; m_act_b = '0; m_act_c = '0; m_en = 1'b0;
    m_fault = 1'b0; m_pend = 1'b0; m_err = 0; m_wd = 0;
  endtask

  task automatic modelStep(input logic fv, input logic [32:0] fd, input logic cs);
    logic        good, expire;
    logic [3:0]  addr;
    logic [15:0] n_sh_a, n_sh_b, n_sh_c;
    logic        n_sh_en, n_fault, n_pend;
    addr    = fd[31:28];
    good    = fv && ((^fd) == 1'b0) && (addr < 4'd4);
    expire  = !m_fault && !good && (m_wd == WDOG - 1);
    n_sh_a  = m_sh_a; n_sh_b = m_sh_b; n_sh_c = m_sh_c; n_sh_en = m_sh_en;
    n_fault = m_fault; n_pend = m_pend;
    if (expire) begin
      m_act_a = '0; m_act_b = '0; m_act_c = '0; m_en = 1'b0;
      n_fault = 1'b1; n_pend = 1'b0;
    end else if (m_pend && cs) begin
      m_act_a = m_sh_a; m_act_b = m_sh_b; m_act_c = m_sh_c; m_en = m_sh_en;
      n_pend = 1'b0;
    end
    if (good) begin
      case (addr)
        4'd0: n_sh_a = fd[15:0];
        4'd1: n_sh_b = fd[15:0];
        4'd2: n_sh_c = fd[15:0];
        default: begin
          n_sh_en = fd[0];
          if (!m_fault) n_pend = 1'b1;
          else if (fd[1]) begin
            n_fault = 1'b0;
            n_pend  = 1'b1;
          end
        end
      endcase
    end
    if (fv && !good && m_err < 255) m_err++;
    if (good || m_wd == WDOG - 1) m_wd = 0;
    else m_wd++;
    m_sh_a = n_sh_a; m_sh_b = n_sh_b; m_sh_c = n_sh_c; m_sh_en = n_sh_en;
    m_fault = n_fault; m_pend = n_pend;
  endtask

  task automatic pushExpected();
    exp_t e;
    e.a = m_act_a; e.b = m_act_b; e.c = m_act_c; e.en = m_en;
    e.flt = m_fault; e.pend = m_pend; e.err = 8'(m_err);
    exp_q.push_back(e);
  endtask

  task automatic compareNext();
    exp_t e;
    if (exp_q.size() == 0) begin
      checkOutput("sb_queue_empty", 32'd0, 32'd1);
      return;
    end
    e = exp_q.pop_front();
    checkOutput("sb_duty_a", 32'(duty_a), 32'(e.a));
    checkOutput("sb_duty_b", 32'(duty_b), 32'(e.b));
    checkOutput("sb_duty_c", 32'(duty_c), 32'(e.c));
    checkOutput("sb_pwm_enable", 32'(pwm_enable), 32'(e.en));
    checkOutput("sb_fault", 32'(fault), 32'(e.flt));
    checkOutput("sb_commit_pending", 32'(commit_pending), 32'(e.pend));
    checkOutput("sb_frame_err_cnt", 32'(frame_err_cnt), 32'(e.err));
  endtask

  task automatic applyStimulus(input logic fv, input logic [32:0] fd, input logic cs);
    @(negedge clk);
    frame_valid  = fv;
    frame_data   = fd;
    carrier_sync = cs;
    modelStep(fv, fd, cs);
    pushExpected();
    @(posedge clk);
    #1;
    compareNext();
  endtask

  task automatic applyReset();
    @(negedge clk);
    frame_valid  = 1'b0;
    frame_data   = '0;
    carrier_sync = 1'b0;
    rst          = 1'b1;
    #1;
    modelReset();
    pushExpected();
    compareNext();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic sendFrame(input logic [3:0] addr, input logic [27:0] payload);
    applyStimulus(1'b1, makeFrame(addr, payload, 1'b0), 1'b0);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 33'd0, 1'b0);
  endtask

  task automatic syncPulse();
    applyStimulus(1'b0, 33'd0, 1'b1);
  endtask

  initial begin
    rst          = 1'b1;
    frame_valid  = 1'b0;
    frame_data   = '0;
    carrier_sync = 1'b0;
    modelReset();

    // Reset values
    applyReset();
    checkOutput("reset_duty_a", 32'(duty_a), 32'h0);
    checkOutput("reset_pending", 32'(commit_pending), 32'h0);
    checkOutput("reset_errcnt", 32'(frame_err_cnt), 32'h0);

    // Basic commit on sync
    sendFrame(4'd0, 28'h1234);
    sendFrame(4'd1, 28'h0800);
    sendFrame(4'd2, 28'h0FFF);
    sendFrame(4'd3, 28'h1);
    checkOutput("precommit_duty_a", 32'(duty_a), 32'h0);
    checkOutput("precommit_pending", 32'(commit_pending), 32'h1);
    syncPulse();
    checkOutput("commit_duty_a", 32'(duty_a), 32'h1234);
    checkOutput("commit_duty_b", 32'(duty_b), 32'h0800);
    checkOutput("commit_duty_c", 32'(duty_c), 32'h0FFF);
    checkOutput("commit_enable", 32'(pwm_enable), 32'h1);
    checkOutput("commit_pending_clr", 32'(commit_pending), 32'h0);

    // Bad frames and saturating error counter
    applyStimulus(1'b1, makeFrame(4'd0, 28'hDEAD, 1'b1), 1'b0);
    applyStimulus(1'b1, makeFrame(4'd7, 28'h0042, 1'b0), 1'b0);
    checkOutput("errcnt_two", 32'(frame_err_cnt), 32'd2);
    for (int i = 0; i < 300; i++) begin
      if (i % 50 == 0) sendFrame(4'd2, 28'h0FFF);
      applyStimulus(1'b1, makeFrame(4'(4 + (i % 12)), 28'(i), 1'b0), 1'b0);
    end
    checkOutput("errcnt_saturated", 32'(frame_err_cnt), 32'd255);

    // Watchdog expiry and recovery
    sendFrame(4'd2, 28'h0FFF);
    idleCycles(WDOG - 1);
    checkOutput("wdog_not_yet", 32'(fault), 32'h0);
    idleCycles(1);
    checkOutput("wdog_fault", 32'(fault), 32'h1);
    checkOutput("wdog_duty_a_zero", 32'(duty_a), 32'h0);
    checkOutput("wdog_enable_zero", 32'(pwm_enable), 32'h0);
    sendFrame(4'd3, 28'h3);
    checkOutput("fclr_fault", 32'(fault), 32'h0);
    syncPulse();
    checkOutput("restore_duty_a", 32'(duty_a), 32'h1234);
    checkOutput("restore_duty_c", 32'(duty_c), 32'h0FFF);
    checkOutput("restore_enable", 32'(pwm_enable), 32'h1);

    // Frames coinciding with carrier_sync
    applyStimulus(1'b1, makeFrame(4'd0, 28'h0100, 1'b0), 1'b1);
    checkOutput("same_cycle_no_commit", 32'(duty_a), 32'h1234);
    applyStimulus(1'b1, makeFrame(4'd3, 28'h1, 1'b0), 1'b1);
    checkOutput("same_cycle_ctrl_arms", 32'(commit_pending), 32'h1);
    checkOutput("same_cycle_ctrl_hold", 32'(duty_a), 32'h1234);
    syncPulse();
    checkOutput("next_sync_commit", 32'(duty_a), 32'h0100);
    sendFrame(4'd1, 28'h0222);
    sendFrame(4'd3, 28'h1);
    applyStimulus(1'b1, makeFrame(4'd1, 28'h0333, 1'b0), 1'b1);
    checkOutput("commit_old_shadow", 32'(duty_b), 32'h0222);
    syncPulse();
    checkOutput("no_rearm_commit", 32'(duty_b), 32'h0222);

    // Watchdog expiry coinciding with sync while armed
    sendFrame(4'd3, 28'h1);
    idleCycles(WDOG - 1);
    syncPulse();
    checkOutput("expire_sync_fault", 32'(fault), 32'h1);
    checkOutput("expire_sync_duty_a", 32'(duty_a), 32'h0);
    checkOutput("expire_sync_pending", 32'(commit_pending), 32'h0);

    // Reset while armed
    sendFrame(4'd3, 28'h3);
    checkOutput("armed_before_reset", 32'(commit_pending), 32'h1);
    applyReset();
    checkOutput("midreset_pending", 32'(commit_pending), 32'h0);
    checkOutput("midreset_fault", 32'(fault), 32'h0);
    syncPulse();
    checkOutput("post_reset_sync_duty_b", 32'(duty_b), 32'h0);
    checkOutput("post_reset_sync_enable", 32'(pwm_enable), 32'h0);
    sendFrame(4'd0, 28'h0055);
    sendFrame(4'd3, 28'h1);
    syncPulse();
    checkOutput("post_reset_commit", 32'(duty_a), 32'h0055);
    checkOutput("post_reset_enable", 32'(pwm_enable), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
